hazard_unit: RTL and testbench

Hazard and forwarding controller for the five-stage in-order pipeline. It watches the source registers in Decode and the contents of the Decode/Execute register. It tracks in-flight destination registers through Memory and Writeback with an internal shadow pipeline. It drives stall, flush (including the Decode/Execute register clear) and forwarding-mux selects, and keeps stall/flush event counters for performance debug.

---
 rtl/hazard_unit_pkg.sv | 18 +
 rtl/hazard_unit_fwd_sel.sv | 28 ++
 rtl/hazard_unit.sv | 119 +++++++++++
 tb/tb_hazard_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared pipeline encodings for the hazard unit
// Contents: result-source codes, forward-select codes, x0 register address.
package hazard_unit_pkg;

    // Result source held in the Decode/Execute register
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    // ALU operand forwarding-mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Hardwired-zero register; never a real dependency
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// rtl/hazard_unit_fwd_sel.sv - forwarding select for one ALU operand
// Ports:
//   srcAd            source register address held in Decode/Execute
//   rdm, regWrtm     Memory-stage shadow destination and write enable
//   rdw, regWrtw     Writeback-stage shadow destination and write enable
//   fwd              operand select (FWD_RF / FWD_WB / FWD_MEM)
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] srcAd,
    input  logic [4:0] rdm,
    input  logic       regWrtm,
    input  logic [4:0] rdw,
    input  logic       regWrtw,
    output logic [1:0] fwd
);

    // Memory is checked first: it holds the younger, more recent value.
    always_comb begin
        fwd = FWD_RF;
        if (regWrtm && (rdm != REG_X0) && (rdm == srcAd)) begin
            fwd = FWD_MEM;
        end else if (regWrtw && (rdw != REG_X0) && (rdw == srcAd)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall, flush and forwarding control for the 5-stage pipeline
// Ports:
//   clk, rst                 pipeline clock, synchronous active-high reset
//   ad1d, ad2d               source addresses of the Decode instruction
//   ad1e, ad2e, rde          source/destination addresses in Decode/Execute
//   regWrte, resltSrce       Execute write enable and result source
//   pcSrce                   taken branch/jump resolved in Execute
//   stallf, stalld           hold PC and Fetch/Decode register
//   flushd, flushe           clear Fetch/Decode and Decode/Execute registers
//   fwdae, fwdbe             ALU operand A/B forwarding selects
//   stallcnt, flushcnt       load-use stall and control flush cycle counters
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ad1d,
    input  logic [4:0]       ad2d,
    input  logic [4:0]       ad1e,
    input  logic [4:0]       ad2e,
    input  logic [4:0]       rde,
    input  logic             regWrte,
    input  logic [1:0]       resltSrce,
    input  logic             pcSrce,
    output logic             stallf,
    output logic             stalld,
    output logic             flushd,
    output logic             flushe,
    output logic [1:0]       fwdae,
    output logic [1:0]       fwdbe,
    output logic [CNT_W-1:0] stallcnt,
    output logic [CNT_W-1:0] flushcnt
);

    // Shadow copies of the in-flight destinations. They advance every edge,
    // ignoring stalls: the Execute instruction always moves on to Memory.
    logic [4:0] rdm;
    logic [4:0] rdw;
    logic       regWrtm;
    logic       regWrtw;

    logic [1:0] fwdaRaw;
    logic [1:0] fwdbRaw;
    logic       lwstall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdm     <= REG_X0;
            rdw     <= REG_X0;
            regWrtm <= 1'b0;
            regWrtw <= 1'b0;
        end else begin
            rdm     <= rde;
            regWrtm <= regWrte;
            rdw     <= rdm;
            regWrtw <= regWrtm;
        end
    end

    fwd_sel u_fwd_a (
        .srcAd   (ad1e),
        .rdm     (rdm),
        .regWrtm (regWrtm),
        .rdw     (rdw),
        .regWrtw (regWrtw),
        .fwd     (fwdaRaw)
    );

    fwd_sel u_fwd_b (
        .srcAd   (ad2e),
        .rdm     (rdm),
        .regWrtm (regWrtm),
        .rdw     (rdw),
        .regWrtw (regWrtw),
        .fwd     (fwdbRaw)
    );

    // A load in Execute whose result the Decode instruction needs cannot be
    // forwarded in time; hold Decode one cycle and insert a bubble.
    assign lwstall = (resltSrce == RS_LOAD) && (rde != REG_X0)
                     && ((rde == ad1d) || (rde == ad2d));

    // A taken branch discards the Decode instruction, so a pending load-use
    // stall on it is pointless: the flush wins and the stall is dropped.
    always_comb begin
        stallf = lwstall && !pcSrce;
        stalld = lwstall && !pcSrce;
        flushd = pcSrce;
        flushe = lwstall || pcSrce;
        fwdae  = fwdaRaw;
        fwdbe  = fwdbRaw;
        if (rst) begin
            stallf = 1'b0;
            stalld = 1'b0;
            flushd = 1'b1;
            flushe = 1'b1;
            fwdae  = FWD_RF;
            fwdbe  = FWD_RF;
        end
    end

    // Event counters wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallcnt <= '0;
            flushcnt <= '0;
        end else begin
            if (stallf) begin
                stallcnt <= stallcnt + CNT_W'(1);
            end
            if (pcSrce) begin
                flushcnt <= flushcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam int CW = 4;

    typedef struct {
        logic       rst;
        logic [4:0] ad1d;
        logic [4:0] ad2d;
        logic [4:0] ad1e;
        logic [4:0] ad2e;
        logic [4:0] rde;
        logic       regWrte;
        logic [1:0] resltSrce;
        logic       pcSrce;
        logic       eStall;
        logic       eFlushd;
        logic       eFlushe;
        logic [1:0] eFwda;
        logic [1:0] eFwdb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ad1d, ad2d, ad1e, ad2e, rde;
    logic          regWrte;
    logic [1:0]    resltSrce;
    logic          pcSrce;
    logic          stallf, stalld, flushd, flushe;
    logic [1:0]    fwdae, fwdbe;
    logic [CW-1:0] stallcnt, flushcnt;

    int nTests = 0;
    int nFail  = 0;

    logic [CW-1:0] mStall = '0;
    logic [CW-1:0] mFlush = '0;

    vec_t sbq[$];
    vec_t tbl[16];
    vec_t sv, rv, pv, iv;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ad1d      (ad1d),
        .ad2d      (ad2d),
        .ad1e      (ad1e),
        .ad2e      (ad2e),
        .rde       (rde),
        .regWrte   (regWrte),
        .resltSrce (resltSrce),
        .pcSrce    (pcSrce),
        .stallf    (stallf),
        .stalld    (stalld),
        .flushd    (flushd),
        .flushe    (flushe),
        .fwdae     (fwdae),
        .fwdbe     (fwdbe),
        .stallcnt  (stallcnt),
        .flushcnt  (flushcnt)
    );

    task automatic chk(input string name, input int idx, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        rst       = v.rst;
        ad1d      = v.ad1d;
        ad2d      = v.ad2d;
        ad1e      = v.ad1e;
        ad2e      = v.ad2e;
        rde       = v.rde;
        regWrte   = v.regWrte;
        resltSrce = v.resltSrce;
        pcSrce    = v.pcSrce;
        sbq.push_back(v);
        @(negedge clk);
        if (sbq.size() == 0) begin
            nTests++;
            nFail++;
            $display("FAIL scoreboard_empty vec %0d", idx);
        end else begin
            e = sbq.pop_front();
            chk("stallf",   idx, int'(stallf),   int'(e.eStall));
            chk("stalld",   idx, int'(stalld),   int'(e.eStall));
            chk("flushd",   idx, int'(flushd),   int'(e.eFlushd));
            chk("flushe",   idx, int'(flushe),   int'(e.eFlushe));
            chk("fwdae",    idx, int'(fwdae),    int'(e.eFwda));
            chk("fwdbe",    idx, int'(fwdbe),    int'(e.eFwdb));
            chk("stallcnt", idx, int'(stallcnt), int'(mStall));
            chk("flushcnt", idx, int'(flushcnt), int'(mFlush));
            if (e.rst) begin
                mStall = '0;
                mFlush = '0;
            end else begin
                if (e.eStall) mStall = mStall + 1'b1;
                if (e.pcSrce) mFlush = mFlush + 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; ad1d = '0; ad2d = '0; ad1e = '0; ad2e = '0; rde = '0;
        regWrte = 1'b0; resltSrce = 2'b00; pcSrce = 1'b0;

        //          rst ad1d ad2d ad1e ad2e rde wr rs pc  st fd fe fa fb
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 2'd0, 0,   0, 1, 1, 2'd0, 2'd0};
        tbl[1]  = '{1, 0, 0, 5, 0, 5, 1, 2'd0, 0,   0, 1, 1, 2'd0, 2'd0};
        tbl[2]  = '{0, 0, 0, 5, 5, 5, 1, 2'd0, 0,   0, 0, 0, 2'd0, 2'd0};
        tbl[3]  = '{0, 0, 0, 5, 0, 6, 1, 2'd0, 0,   0, 0, 0, 2'd2, 2'd0};
        tbl[4]  = '{0, 0, 0, 5, 6, 7, 1, 2'd0, 0,   0, 0, 0, 2'd1, 2'd2};
        tbl[5]  = '{0, 0, 0, 0, 7, 7, 1, 2'd0, 0,   0, 0, 0, 2'd0, 2'd2};
        tbl[6]  = '{0, 0, 0, 7, 7, 0, 1, 2'd0, 0,   0, 0, 0, 2'd2, 2'd2};
        tbl[7]  = '{0, 0, 0, 0, 7, 9, 0, 2'd0, 0,   0, 0, 0, 2'd0, 2'd1};
        tbl[8]  = '{0, 0, 3, 9, 0, 3, 1, 2'd1, 0,   1, 0, 1, 2'd0, 2'd0};
        tbl[9]  = '{0, 0, 3, 0, 0, 0, 0, 2'd0, 0,   0, 0, 0, 2'd0, 2'd0};
        tbl[10] = '{0, 0, 0, 3, 9, 0, 0, 2'd0, 0,   0, 0, 0, 2'd1, 2'd0};
        tbl[11] = '{0, 0, 0, 0, 0, 4, 1, 2'd0, 1,   0, 1, 1, 2'd0, 2'd0};
        tbl[12] = '{0, 4, 0, 4, 0, 4, 1, 2'd1, 1,   0, 1, 1, 2'd2, 2'd0};
        tbl[13] = '{0, 0, 0, 0, 4, 0, 0, 2'd0, 0,   0, 0, 0, 2'd0, 2'd2};
        tbl[14] = '{0, 0, 0, 4, 0, 0, 0, 2'd1, 0,   0, 0, 0, 2'd1, 2'd0};
        tbl[15] = '{0, 8, 0, 0, 0, 8, 1, 2'd1, 0,   1, 0, 1, 2'd0, 2'd0};

        sv = '{0, 3, 0, 0, 0, 3, 1, 2'd1, 0,   1, 0, 1, 2'd0, 2'd0};
        rv = '{1, 3, 0, 0, 0, 3, 1, 2'd1, 0,   0, 1, 1, 2'd0, 2'd0};
        pv = '{0, 0, 0, 3, 3, 0, 0, 2'd0, 0,   0, 0, 0, 2'd0, 2'd0};
        iv = '{0, 0, 0, 0, 0, 0, 0, 2'd0, 0,   0, 0, 0, 2'd0, 2'd0};

        for (int i = 0; i < 16; i++) begin
            applyVec(tbl[i], i);
        end

        // Build up to five stall cycles, then reset mid-run.
        for (int i = 0; i < 20 && mStall != 4'd5; i++) begin
            applyVec(sv, 100 + i);
        end
        applyVec(rv, 200);
        applyVec(pv, 201);
        chk("post_rst_stallcnt", 201, int'(stallcnt), 0);
        chk("post_rst_flushcnt", 201, int'(flushcnt), 0);

        // Sixteen stall cycles wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            applyVec(sv, 300 + i);
        end
        applyVec(iv, 316);
        chk("wrap_stallcnt", 316, int'(stallcnt), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
